music_playback_controller: RTL and testbench
============================================

// Module: music_playback_controller
// PURPOSE
//  Sequences playback across NUM_SONGS internal music memories (one per song ROM).
//  Decodes play/pause, stop, next and prev commands into per-memory read_en and read_rst.
//  Muxes the selected memory's note onto note_out and detects end-of-song for loop or stop.
//  Tracks elapsed play time. Sits between the button debounce/UI logic and the tone generator.
// PARAMETERS
//  NUM_SONGS    4   number of attached song memories; song index range 0..NUM_SONGS-1
//  SEL_BITS     2   width of song index; SEL_BITS >= clog2(NUM_SONGS)
//  DATA_WIDTH   10  note/octave word width; must match the memories
//  TICK_CYCLES  50000000  clk cycles per elapsed-time second
// PORTS
//  clk          in   1                  system clock, rising edge
//  rst          in   1                  asynchronous reset, active-high
//  cmd_play     in   1                  one-cycle pulse: start or toggle play/pause
//  cmd_stop     in   1                  one-cycle pulse: stop and return to IDLE
//  cmd_next     in   1                  one-cycle pulse: select next song, modulo NUM_SONGS
//  cmd_prev     in   1                  one-cycle pulse: select previous song, modulo NUM_SONGS
//  loop_en      in   1                  level: restart the song on end instead of going to DONE
//  mem_data     in   NUM_SONGS*DATA_WIDTH  memory data_out buses; song k occupies bits [k*DW +: DW]
//  mem_ready    in   NUM_SONGS          memory output_ready flags
//  read_en      out  NUM_SONGS          one-hot read enable for the selected memory
//  read_rst     out  NUM_SONGS          read-pointer reset for the memories
//  note_out     out  DATA_WIDTH         note for the tone generator; 0 = silence
//  note_valid   out  1                  note_out is a live note
//  song_idx     out  SEL_BITS           currently selected song
//  state_out    out  3                  encoded FSM state, for the display
//  song_done    out  1                  high while in DONE
//  elapsed_sec  out  8                  seconds played in the current song; saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE, song_idx=0, started=0, tick counter=0.
//   Outputs at reset: elapsed_sec=0, note_out=0, note_valid=0, song_done=0, read_en=0, read_rst=all 1s.
//  State encoding: IDLE=0, LOAD=1, PLAY=2, PAUSE=3, DONE=4.
//   All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
//  Command priority within one cycle: stop > next > prev > play; lower-priority commands that cycle are dropped.
//  read_rst decode: all 1s in IDLE, LOAD and DONE; all 0s in PLAY and PAUSE.
//  read_en decode: bit song_idx is set only in PLAY; all 0s in every other state.
//  IDLE
//   - next/prev: song_idx +/-1 with wrap (NUM_SONGS-1 -> 0 and 0 -> NUM_SONGS-1).
//   - play: go to LOAD.
//  LOAD (exactly 1 cycle)
//   - Clear started, elapsed_sec and tick counter; then go to PLAY.
//  PLAY
//   - Each cycle, note_out <= mem_data[song_idx] and note_valid <= mem_ready[song_idx].
//   - When mem_ready[song_idx]=1, set started=1.
//   - End of song: started=1 && mem_ready[song_idx]=0. loop_en=1 -> LOAD; loop_en=0 -> DONE.
//   - play: go to PAUSE. stop: go to IDLE.
//   - next/prev: change song_idx, then go to LOAD (the new song starts immediately).
//   - Tick counter increments each cycle; at TICK_CYCLES-1 it wraps to 0 and elapsed_sec += 1 (saturating).
//  PAUSE
//   - note_out=0, note_valid=0; tick counter and elapsed_sec hold.
//   - Memory pointer holds, since read_en=0 and read_rst=0.
//   - play: go to PLAY and resume from the same note. stop: go to IDLE.
//   - next/prev: change song_idx, then go to LOAD.
//  DONE
//   - song_done=1, note_valid=0, elapsed_sec holds.
//   - play: go to LOAD (replay). stop: go to IDLE.
//   - next/prev: change song_idx, then go to IDLE.
//  Entering IDLE or DONE forces note_out=0 and note_valid=0 on the same edge.
//  Latency:
//   - play pulse in IDLE at edge N: LOAD at N+1, PLAY (read_en high) at N+2.
//   - First note_valid from the memory at N+4: the memory registers output_ready at N+3,
//     and the controller registers note_out at N+4.
//  An asynchronous rst at any point aborts playback; the next clk edge sees the reset values.
//  Changing loop_en mid-song takes effect at the next end-of-song only.
// TESTING
//  Use a stub memory: 4 notes, 3 cycles per note, output_ready modelled as in the real memory. Set TICK_CYCLES=5.
//  1. rst, then cmd_play -> LOAD at +1 cycle, PLAY at +2, read_en=4'b0001.
//     note_valid=1 by +4; note_out steps through 4 values; then DONE, song_done=1, read_en=0.
//  2. cmd_prev in IDLE at song_idx=0 -> song_idx=3. cmd_next at 3 -> 0. cmd_next and cmd_prev together -> +1.
//  3. PLAY, cmd_play after note 2 -> PAUSE: note_valid=0, elapsed_sec frozen.
//     cmd_play again -> resume at note 2, with no read_rst pulse.
//  4. loop_en=1: end of song -> exactly one LOAD cycle with read_rst high, then PLAY.
//     elapsed_sec restarts at 0 and playback repeats 3 times.
//  5. cmd_stop and cmd_play in the same cycle in PLAY -> IDLE, read_rst all 1s, note_out=0.
//  6. Assert rst asynchronously mid-PLAY (between edges) -> outputs reach reset values immediately.
//     Run >1275 ticks of play -> elapsed_sec saturates at 255.

Source files
------------

// File: rtl/music_playback_controller.sv
// Playback sequencer for NUM_SONGS song memories: command decode, per-memory
// read control, note mux to the tone generator, end-of-song handling and play timer.
module music_playback_controller #(
   parameter int NUM_SONGS   = 4,
   parameter int SEL_BITS    = 2,
   parameter int DATA_WIDTH  = 10,
   parameter int TICK_CYCLES = 50000000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_play,
   input  logic                            cmd_stop,
   input  logic                            cmd_next,
   input  logic                            cmd_prev,
   input  logic                            loop_en,
   input  logic [NUM_SONGS*DATA_WIDTH-1:0] mem_data,
   input  logic [NUM_SONGS-1:0]            mem_ready,
   output logic [NUM_SONGS-1:0]            read_en,
   output logic [NUM_SONGS-1:0]            read_rst,
   output logic [DATA_WIDTH-1:0]           note_out,
   output logic                            note_valid,
   output logic [SEL_BITS-1:0]             song_idx,
   output logic [2:0]                      state_out,
   output logic                            song_done,
   output logic [7:0]                      elapsed_sec
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_STOP,
      CMD_NEXT,
      CMD_PREV,
      CMD_PLAY
   } cmd_t;

   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   state_t              state;
   cmd_t                cmd;
   logic                started;
   logic [TICK_W-1:0]   tick_cnt;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                sel_ready;

   // Wrapping song selection; works for any NUM_SONGS, not only powers of two.
   function automatic logic [SEL_BITS-1:0] step_idx(input logic [SEL_BITS-1:0] idx,
                                                     input cmd_t c);
      logic [SEL_BITS-1:0] res;
      res = idx;
      if (c == CMD_NEXT) begin
         res = (idx == SEL_BITS'(NUM_SONGS - 1)) ? '0 : idx + 1'b1;
      end else if (c == CMD_PREV) begin
         res = (idx == '0) ? SEL_BITS'(NUM_SONGS - 1) : idx - 1'b1;
      end
      return res;
   endfunction

   always_comb begin
      cmd = CMD_NONE;
      if (cmd_stop)      cmd = CMD_STOP;
      else if (cmd_next) cmd = CMD_NEXT;
      else if (cmd_prev) cmd = CMD_PREV;
      else if (cmd_play) cmd = CMD_PLAY;
   end

   always_comb begin
      sel_data  = mem_data[song_idx*DATA_WIDTH +: DATA_WIDTH];
      sel_ready = mem_ready[song_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         song_idx    <= '0;
         started     <= 1'b0;
         tick_cnt    <= '0;
         elapsed_sec <= '0;
         note_out    <= '0;
         note_valid  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the later assignment in a branch overrides this silent default.
         note_out   <= '0;
         note_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               case (cmd)
                  CMD_NEXT, CMD_PREV: song_idx <= step_idx(song_idx, cmd);
                  CMD_PLAY:           state    <= S_LOAD;
                  default: ;
               endcase
            end
            S_LOAD: begin
               started     <= 1'b0;
               tick_cnt    <= '0;
               elapsed_sec <= '0;
               state       <= S_PLAY;
            end
            S_PLAY: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  if (elapsed_sec != 8'hFF) elapsed_sec <= elapsed_sec + 1'b1;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
               if (sel_ready) started <= 1'b1;
               case (cmd)
                  CMD_STOP: state <= S_IDLE;
                  CMD_NEXT, CMD_PREV: begin
                     song_idx <= step_idx(song_idx, cmd);
                     state    <= S_LOAD;
                  end
                  CMD_PLAY: state <= S_PAUSE;
                  default: begin
                     // Memory dropping ready after having produced notes marks the end of the song.
                     if (started && !sel_ready) begin
                        state <= loop_en ? S_LOAD : S_DONE;
                     end else begin
                        note_out   <= sel_data;
                        note_valid <= sel_ready;
                     end
                  end
               endcase
            end
            S_PAUSE: begin
               case (cmd)
                  CMD_STOP: state <= S_IDLE;
                  CMD_NEXT, CMD_PREV: begin
                     song_idx <= step_idx(song_idx, cmd);
                     state    <= S_LOAD;
                  end
                  CMD_PLAY: state <= S_PLAY;
                  default: ;
               endcase
            end
            S_DONE: begin
               case (cmd)
                  CMD_STOP: state <= S_IDLE;
                  CMD_NEXT, CMD_PREV: begin
                     song_idx <= step_idx(song_idx, cmd);
                     state    <= S_IDLE;
                  end
                  CMD_PLAY: state <= S_LOAD;
                  default: ;
               endcase
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory control decoded from the registered state only.
   always_comb begin
      // NOTE: default first so every path assigns read_en and no latch is inferred.
      read_en = '0;
      if (state == S_PLAY) read_en[song_idx] = 1'b1;
   end

   assign read_rst  = (state == S_PLAY || state == S_PAUSE) ? '0 : '1;
   assign song_done = (state == S_DONE);
   assign state_out = state;

endmodule

// File: tb/tb_music_playback_controller.sv
// Self-checking bench: stub song memories, a behavioural reference model,
// a per-cycle compare process, directed scenarios and a random command phase.
module tb_music_playback_controller;

   localparam int NS    = 4;
   localparam int SB    = 2;
   localparam int DW    = 10;
   localparam int TC    = 5;
   localparam int NOTES = 4;
   localparam int CPN   = 3;
   localparam int LONG_NOTES = 800;

   localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_PAUSE = 3, M_DONE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_play = 1'b0, cmd_stop = 1'b0, cmd_next = 1'b0, cmd_prev = 1'b0;
   logic              loop_en = 1'b0;
   logic [NS*DW-1:0]  mem_data;
   logic [NS-1:0]     mem_ready;
   logic [NS-1:0]     read_en, read_rst;
   logic [DW-1:0]     note_out;
   logic              note_valid;
   logic [SB-1:0]     song_idx;
   logic [2:0]        state_out;
   logic              song_done;
   logic [7:0]        elapsed_sec;

   int  vectors = 0;
   int  miscompares = 0;
   bit  chk_en = 1'b0;
   bit  long_mode = 1'b0;

   music_playback_controller #(
      .NUM_SONGS(NS), .SEL_BITS(SB), .DATA_WIDTH(DW), .TICK_CYCLES(TC)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_play(cmd_play), .cmd_stop(cmd_stop), .cmd_next(cmd_next), .cmd_prev(cmd_prev),
      .loop_en(loop_en), .mem_data(mem_data), .mem_ready(mem_ready),
      .read_en(read_en), .read_rst(read_rst), .note_out(note_out), .note_valid(note_valid),
      .song_idx(song_idx), .state_out(state_out), .song_done(song_done),
      .elapsed_sec(elapsed_sec)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] note_of(input int k, input int p);
      return DW'(k * 100 + p * 7 + 3);
   endfunction

   function automatic int song_len(input int k);
      return (long_mode && k == NS - 1) ? LONG_NOTES : NOTES;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stub song memory: NOTES notes, CPN cycles each, ready registered like the real part.
   int s_ptr [NS];
   int s_cnt [NS];
   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) begin
         if (rst || read_rst[k]) begin
            s_ptr[k] <= 0;
            s_cnt[k] <= 0;
            mem_ready[k] <= 1'b0;
            mem_data[k*DW +: DW] <= '0;
         end else if (read_en[k]) begin
            if (s_ptr[k] < song_len(k)) begin
               mem_ready[k] <= 1'b1;
               mem_data[k*DW +: DW] <= note_of(k, s_ptr[k]);
               if (s_cnt[k] == CPN - 1) begin
                  s_cnt[k] <= 0;
                  s_ptr[k] <= s_ptr[k] + 1;
               end else begin
                  s_cnt[k] <= s_cnt[k] + 1;
               end
            end else begin
               mem_ready[k] <= 1'b0;
               mem_data[k*DW +: DW] <= '0;
            end
         end
      end
   end

   // Reference model: mode, selected song, cycles played; elapsed time is derived by division.
   int            m_mode = M_IDLE, m_idx = 0, m_pc = 0, m_next;
   bit            m_started = 1'b0, m_valid = 1'b0;
   logic [DW-1:0] m_note = '0;
   bit            c_s, c_n, c_p, c_y, m_rdy, m_end;
   logic [DW-1:0] m_dat;

   function automatic int new_idx(input int idx, input bit nxt);
      return nxt ? (idx + 1) % NS : (idx + NS - 1) % NS;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_IDLE; m_idx = 0; m_pc = 0; m_started = 1'b0;
         m_note = '0; m_valid = 1'b0;
      end else begin
         c_s = cmd_stop;
         c_n = !c_s && cmd_next;
         c_p = !c_s && !c_n && cmd_prev;
         c_y = !c_s && !c_n && !c_p && cmd_play;
         m_rdy = mem_ready[m_idx];
         m_dat = mem_data[m_idx*DW +: DW];
         m_next = m_mode;
         m_note = '0;
         m_valid = 1'b0;
         if (m_mode == M_IDLE) begin
            if (c_n || c_p) m_idx = new_idx(m_idx, c_n);
            else if (c_y) m_next = M_LOAD;
         end else if (m_mode == M_LOAD) begin
            m_started = 1'b0; m_pc = 0; m_next = M_PLAY;
         end else if (m_mode == M_PLAY) begin
            m_end = m_started && !m_rdy;
            m_pc++;
            if (m_rdy) m_started = 1'b1;
            if (c_s) m_next = M_IDLE;
            else if (c_n || c_p) begin m_idx = new_idx(m_idx, c_n); m_next = M_LOAD; end
            else if (c_y) m_next = M_PAUSE;
            else if (m_end) m_next = loop_en ? M_LOAD : M_DONE;
            if (m_next == M_PLAY) begin m_note = m_dat; m_valid = m_rdy; end
         end else if (m_mode == M_PAUSE) begin
            if (c_s) m_next = M_IDLE;
            else if (c_n || c_p) begin m_idx = new_idx(m_idx, c_n); m_next = M_LOAD; end
            else if (c_y) m_next = M_PLAY;
         end else begin
            if (c_s) m_next = M_IDLE;
            else if (c_n || c_p) begin m_idx = new_idx(m_idx, c_n); m_next = M_IDLE; end
            else if (c_y) m_next = M_LOAD;
         end
         m_mode = m_next;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         logic [NS-1:0] e_en;
         e_en = '0;
         if (m_mode == M_PLAY) e_en[m_idx] = 1'b1;
         check("state_out", state_out, m_mode);
         check("song_idx", song_idx, m_idx);
         check("read_en", read_en, e_en);
         check("read_rst", read_rst, (m_mode == M_PLAY || m_mode == M_PAUSE) ? 0 : 4'hF);
         check("note_out", note_out, m_note);
         check("note_valid", note_valid, m_valid);
         check("song_done", song_done, m_mode == M_DONE);
         check("elapsed_sec", elapsed_sec, (m_pc / TC > 255) ? 255 : m_pc / TC);
      end
   end

   task automatic pulse(input bit s, input bit n, input bit p, input bit y);
      cmd_stop = s; cmd_next = n; cmd_prev = p; cmd_play = y;
      @(negedge clk);
      cmd_stop = 1'b0; cmd_next = 1'b0; cmd_prev = 1'b0; cmd_play = 1'b0;
   endtask

   task automatic wait_for_state(input string name, input logic [2:0] s, input int max_cyc);
      int n;
      n = 0;
      while (state_out !== s && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, state_out, s);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, state_out, 0);
      check({tag, "_idx"}, song_idx, 0);
      check({tag, "_read_rst"}, read_rst, 4'hF);
      check({tag, "_read_en"}, read_en, 0);
      check({tag, "_note"}, note_out, 0);
      check({tag, "_valid"}, note_valid, 0);
      check({tag, "_done"}, song_done, 0);
      check({tag, "_elapsed"}, elapsed_sec, 0);
   endtask

   initial begin
      logic [DW-1:0] q[$];
      int n;
      logic [7:0] held;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      chk_en = 1'b1;

      // 1: play latency and one full song into DONE
      pulse(0, 0, 0, 1);
      check("t1_load", state_out, M_LOAD);
      @(negedge clk);
      check("t1_play", state_out, M_PLAY);
      check("t1_read_en", read_en, 4'b0001);
      repeat (2) @(negedge clk);
      check("t1_first_valid", note_valid, 1);
      check("t1_first_note", note_out, note_of(0, 0));
      n = 0;
      while (state_out == 3'(M_PLAY) && n < 40) begin
         if (note_valid && (q.size() == 0 || q[$] != note_out)) q.push_back(note_out);
         @(negedge clk);
         n++;
      end
      check("t1_done_latency", n, 12);
      check("t1_done_state", state_out, M_DONE);
      check("t1_song_done", song_done, 1);
      check("t1_read_en_off", read_en, 0);
      check("t1_note_count", q.size(), NOTES);
      for (int i = 0; i < NOTES && i < q.size(); i++) check("t1_note_seq", q[i], note_of(0, i));

      // 2: selection wrap and command priority in IDLE
      pulse(1, 0, 0, 0);
      check("t2_idle", state_out, M_IDLE);
      pulse(0, 0, 1, 0);
      check("t2_prev_wrap", song_idx, 3);
      pulse(0, 1, 0, 0);
      check("t2_next_wrap", song_idx, 0);
      pulse(0, 1, 1, 0);
      check("t2_next_beats_prev", song_idx, 1);
      pulse(0, 0, 1, 0);
      check("t2_back_to_0", song_idx, 0);

      // 3: pause freezes time and resumes on the same note
      pulse(0, 0, 0, 1);
      n = 0;
      while (note_out !== note_of(0, 2) && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("t3_reach_note2", note_out, note_of(0, 2));
      pulse(0, 0, 0, 1);
      check("t3_pause", state_out, M_PAUSE);
      check("t3_pause_silent", note_valid, 0);
      held = elapsed_sec;
      repeat (6) @(negedge clk);
      check("t3_elapsed_frozen", elapsed_sec, held);
      check("t3_no_rst", read_rst, 0);
      pulse(0, 0, 0, 1);
      check("t3_resume", state_out, M_PLAY);
      check("t3_resume_no_rst", read_rst, 0);
      @(negedge clk);
      check("t3_resume_valid", note_valid, 1);
      check("t3_resume_note", note_out, note_of(0, 2));
      wait_for_state("t3_done", 3'(M_DONE), 60);

      // 4: looping replays with a single LOAD cycle each time
      loop_en = 1'b1;
      pulse(0, 0, 0, 1);
      for (int r = 0; r < 3; r++) begin
         check("t4_load", state_out, M_LOAD);
         check("t4_load_rst", read_rst, 4'hF);
         if (r > 0) check("t4_elapsed_at_end", elapsed_sec, 2);
         @(negedge clk);
         check("t4_single_load", state_out, M_PLAY);
         check("t4_elapsed_restart", elapsed_sec, 0);
         if (r < 2) begin
            wait_for_state("t4_reload", 3'(M_LOAD), 40);
         end else begin
            loop_en = 1'b0;
            wait_for_state("t4_final_done", 3'(M_DONE), 40);
         end
      end

      // 5: stop outranks play
      pulse(0, 0, 0, 1);
      wait_for_state("t5_play", 3'(M_PLAY), 5);
      repeat (5) @(negedge clk);
      pulse(1, 0, 0, 1);
      check("t5_idle", state_out, M_IDLE);
      check("t5_read_rst", read_rst, 4'hF);
      check("t5_note", note_out, 0);
      check("t5_valid", note_valid, 0);

      // 6a: asynchronous reset between edges
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      wait_for_state("t6_play", 3'(M_PLAY), 5);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_values("t6_async");
      @(negedge clk);
      rst = 1'b0;

      // 6b: elapsed time saturates on a long song
      long_mode = 1'b1;
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      n = 0;
      while (elapsed_sec !== 8'd255 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_reach_255", elapsed_sec, 255);
      repeat (200) @(negedge clk);
      check("t6_saturated", elapsed_sec, 255);
      check("t6_still_play", state_out, M_PLAY);
      pulse(1, 0, 0, 0);
      long_mode = 1'b0;

      // Random command phase
      for (int c = 0; c < 4000; c++) begin
         cmd_stop = ($urandom_range(0, 99) < 2);
         cmd_next = ($urandom_range(0, 99) < 3);
         cmd_prev = ($urandom_range(0, 99) < 3);
         cmd_play = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) < 1) loop_en = ~loop_en;
         @(negedge clk);
      end
      cmd_stop = 1'b0; cmd_next = 1'b0; cmd_prev = 1'b0; cmd_play = 1'b0;
      @(negedge clk);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
